spi_xfer_arbiter: RTL and testbench
===================================

Name: spi_xfer_arbiter

Overview:
- Shares one SPI master (mode via cpol/cpha, rate via 16-bit dvsr, 8-bit frames) among NREQ requesters.
- Round-robin grant to one requester at a time.
- Latches that requester's tx byte and mode/rate config, pulses the master's start, waits for its done, then returns the rx byte with a one-cycle ack.
- Sits between the SPI master top and client logic (register file, sensor pollers, ...).

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 65535, watchdog limit in clk cycles; used only with SPI_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester transaction request (level)
- req_data  in  NREQ*8  per-requester tx byte; slot i = bits [8i+7:8i]
- req_cpol  in  NREQ  per-requester clock polarity
- req_cpha  in  NREQ  per-requester clock phase
- req_dvsr  in  NREQ*16  per-requester sclk divisor
- gnt  out  NREQ  one-hot grant, held for the whole transaction
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- rx_data  out  8  received byte; valid while ack is high, held until the next ack
- busy  out  1  high from grant until the cycle after ack
- spi_start  out  1  one-cycle start pulse to the SPI master
- spi_din  out  8  tx byte to the master
- spi_dvsr  out  16  divisor to the master
- spi_cpol  out  1  polarity to the master
- spi_cpha  out  1  phase to the master
- spi_done  in  1  master completion pulse
- spi_dout  in  8  master rx byte, valid with spi_done

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = 0 (requester 0 has highest priority).
- FSM IDLE -> SETUP -> START -> WAIT -> DONE -> IDLE.
- IDLE: if any req bit is set, pick the first set bit searching from the pointer upward, wrapping modulo NREQ.
  - Register gnt one-hot, and latch that requester's data/cpol/cpha/dvsr into spi_* output registers.
  - busy goes high; go to SETUP.
  - If no req is set, stay in IDLE.
- SETUP: one cycle so the master sees stable config before start.
- START: spi_start = 1 for exactly one cycle; go to WAIT.
- WAIT: hold all spi_* config; on spi_done, latch spi_dout into rx_data; go to DONE.
- DONE:
  - ack[winner] = 1 for one cycle.
  - Pointer = (winner + 1) mod NREQ.
  - gnt cleared.
  - Go to IDLE.
  - busy drops on the next cycle.
- Minimum latency: req high to spi_start = 3 cycles (IDLE eval, SETUP, START). spi_done to ack = 1 cycle.
- Earliest re-arbitration is the cycle after DONE. Back-to-back requests from different requesters never overlap.
- Requesters keep req high until ack.
  - If req is dropped mid-transaction, the transaction still completes and ack is still issued.
  - If req is still high after ack, the requester re-enters arbitration at the lowest priority.
- Config is sampled only in IDLE. Changes to req_* during a transaction are ignored.
- dvsr is forwarded unchanged, including 0.
- spi_done is ignored outside WAIT.
- Async rst at any point returns to IDLE: gnt/ack/busy/spi_start = 0, pointer = 0, rx_data = 0.
- Single requester (only one req set) is granted regardless of pointer position.

Optional Feature:
- Macro: SPI_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit watchdog counts cycles in WAIT.
  - On reaching TIMEOUT_CYCLES without spi_done, go to DONE with rx_data = 8'hFF and assert an extra output err (1 bit) together with ack.
  - err is 0 otherwise and is reset to 0.
- Without the macro: there is no err port, and WAIT waits indefinitely.

Decomposition:
- Package spi_arb_pkg holds:
  - the FSM state enum (IDLE, SETUP, START, WAIT, DONE), 3 bits;
  - SPI_DW = 8 and DVSR_W = 16;
  - the timeout rx fill value 8'hFF.
- Sub-module rr_arbiter (NREQ parameter): takes req and the pointer, returns the one-hot winner and its index. Purely combinational.

Test Plan:
- Single request: req = 4'b0001, data 8'hA1, cpol 0, cpha 1, dvsr 49; master model returns 8'hA6 → spi_start 3 cycles after req, spi_din = A1, spi_dvsr = 49, ack[0] one cycle after done, rx_data = A6.
- Contention: req = 4'b1011 held continuously → grant order 0, 1, 3, 0 with no overlap; busy drops for exactly one cycle between transactions.
- Config isolation: requester 2 uses mode 3 / dvsr 4 while requester 0 uses mode 0 / dvsr 49 → spi_cpol/cpha/dvsr switch only at grant and stay stable throughout WAIT.
- Req drop and late changes: requester 1 drops req and changes req_data during WAIT → ack[1] still issued; spi_din unchanged.
- Reset in WAIT: assert rst while waiting → outputs all 0 immediately; a spurious spi_done afterwards produces no ack; next arbitration starts from requester 0.
- With SPI_TIMEOUT_EN and TIMEOUT_CYCLES = 20: master never signals done → ack plus err 20 cycles after entering WAIT; rx_data = 8'hFF.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transfer arbiter.
//   arb_state_e     : arbiter FSM state encoding (3 bits)
//   SPI_DW / DVSR_W : SPI frame width and sclk divisor width
//   RX_TIMEOUT_FILL : rx byte returned when the watchdog aborts a transfer
package spi_arb_pkg;

  localparam int unsigned SPI_DW = 8;
  localparam int unsigned DVSR_W = 16;

  localparam logic [SPI_DW-1:0] RX_TIMEOUT_FILL = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Bus bundle between the clients, the arbiter and the SPI master.
//   client side : req, req_data, req_cpol, req_cpha, req_dvsr -> gnt, ack, rx_data, busy
//   master side : spi_start, spi_din, spi_dvsr, spi_cpol, spi_cpha -> spi_done, spi_dout
//   err         : present only when SPI_TIMEOUT_EN is defined
// modport master = arbiter view, modport slave = environment (clients + SPI master) view.
interface spi_xfer_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
);

  logic [NREQ-1:0]                 req;
  logic [NREQ-1:0][SPI_DW-1:0]     req_data;
  logic [NREQ-1:0]                 req_cpol;
  logic [NREQ-1:0]                 req_cpha;
  logic [NREQ-1:0][DVSR_W-1:0]     req_dvsr;
  logic [NREQ-1:0]                 gnt;
  logic [NREQ-1:0]                 ack;
  logic [SPI_DW-1:0]               rx_data;
  logic                            busy;
  logic                            spi_start;
  logic [SPI_DW-1:0]               spi_din;
  logic [DVSR_W-1:0]               spi_dvsr;
  logic                            spi_cpol;
  logic                            spi_cpha;
  logic                            spi_done;
  logic [SPI_DW-1:0]               spi_dout;
`ifdef SPI_TIMEOUT_EN
  logic                            err;
`endif

  modport master (
    input  req, req_data, req_cpol, req_cpha, req_dvsr, spi_done, spi_dout,
    output gnt, ack, rx_data, busy, spi_start, spi_din, spi_dvsr, spi_cpol, spi_cpha
`ifdef SPI_TIMEOUT_EN
    , output err
`endif
  );

  modport slave (
    output req, req_data, req_cpol, req_cpha, req_dvsr, spi_done, spi_dout,
    input  gnt, ack, rx_data, busy, spi_start, spi_din, spi_dvsr, spi_cpol, spi_cpha
`ifdef SPI_TIMEOUT_EN
    , input err
`endif
  );

endinterface

// File: rtl/spi_xfer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
//   req_i   : request vector
//   ptr_i   : highest-priority index
//   gnt_c_o : one-hot winner (zero when no request)
//   idx_c_o : winner index
//   any_c_o : at least one request present
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_c_o,
  output logic [IW-1:0]   idx_c_o,
  output logic            any_c_o
);

  logic [IW-1:0] cand;

  // Scan NREQ slots starting at ptr; the first hit wins.
  always_comb begin
    cand    = '0;
    any_c_o = 1'b0;
    idx_c_o = '0;
    gnt_c_o = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr_i) + k) % NREQ);
      if (!any_c_o && req_i[cand]) begin
        any_c_o = 1'b1;
        idx_c_o = cand;
      end
    end
    gnt_c_o[idx_c_o] = any_c_o;
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master among NREQ requesters with round-robin arbitration.
// Latches the winner's tx byte and mode/rate, pulses spi_start, waits for
// spi_done and returns the rx byte with a one-cycle ack.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : spi_xfer_arbiter_if.master (client handshake + SPI master controls)
// Optional: SPI_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES and the err output.
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_xfer_arbiter_if.master      bus
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("spi_xfer_arbiter: NREQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("spi_xfer_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  arb_state_e          state_q, state_d;
  logic [NREQ-1:0]     gnt_q,   gnt_d;
  logic [NREQ-1:0]     ack_q,   ack_d;
  logic                busy_q,  busy_d;
  logic                start_q, start_d;
  logic [SPI_DW-1:0]   din_q,   din_d;
  logic [DVSR_W-1:0]   dvsr_q,  dvsr_d;
  logic                cpol_q,  cpol_d;
  logic                cpha_q,  cpha_d;
  logic [SPI_DW-1:0]   rx_q,    rx_d;
  logic [IW-1:0]       ptr_q,   ptr_d;
  logic [IW-1:0]       idx_q,   idx_d;

  logic [NREQ-1:0]     arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;

`ifdef SPI_TIMEOUT_EN
  localparam int unsigned WDOG_W = 16;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                err_q,  err_d;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_c_o (arb_gnt),
    .idx_c_o (arb_idx),
    .any_c_o (arb_any)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      din_q   <= '0;
      dvsr_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      rx_q    <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
`ifdef SPI_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      din_q   <= din_d;
      dvsr_q  <= dvsr_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      rx_q    <= rx_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
`ifdef SPI_TIMEOUT_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and next-output logic; pulses (ack, start, err) default low.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    busy_d  = busy_q;
    start_d = 1'b0;
    din_d   = din_q;
    dvsr_d  = dvsr_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    rx_d    = rx_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
`ifdef SPI_TIMEOUT_EN
    wdog_d  = '0;
    err_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // Config is captured only here, so later req_* changes are ignored.
        if (arb_any) begin
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          din_d   = bus.req_data[arb_idx];
          dvsr_d  = bus.req_dvsr[arb_idx];
          cpol_d  = bus.req_cpol[arb_idx];
          cpha_d  = bus.req_cpha[arb_idx];
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        start_d = 1'b1;
        state_d = START;
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.spi_done) begin
          rx_d    = bus.spi_dout;
          ack_d   = gnt_q;
          state_d = DONE;
        end
`ifdef SPI_TIMEOUT_EN
        else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          rx_d    = RX_TIMEOUT_FILL;
          ack_d   = gnt_q;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wdog_d  = wdog_q + WDOG_W'(1);
        end
`endif
      end
      DONE: begin
        // Winner drops to lowest priority for the next round.
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.rx_data   = rx_q;
  assign bus.spi_start = start_q;
  assign bus.spi_din   = din_q;
  assign bus.spi_dvsr  = dvsr_q;
  assign bus.spi_cpol  = cpol_q;
  assign bus.spi_cpha  = cpha_q;
`ifdef SPI_TIMEOUT_EN
  assign bus.err       = err_q;
`endif

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter: stimulus pushes expected transactions,
// a negedge monitor checks spi_start config and ack/rx_data against the queue.
// The SPI master model answers spi_start with spi_din ^ 8'h07 after model_lat cycles.
module tb_spi_xfer_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TMO  = 20;

  typedef struct {
    int          idx;
    logic [7:0]  din;
    logic        cpol;
    logic        cpha;
    logic [15:0] dvsr;
    logic [7:0]  rx;
    logic        err;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_arbiter_if #(.NREQ(NREQ)) bus ();

  spi_xfer_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  txn_t exp_q[$];
  txn_t mon_t;
  int   tests     = 0;
  int   fails     = 0;
  int   cyc       = 0;
  int   req_cyc   = 0;
  bit   lat_chk   = 1'b0;
  int   done_cyc  = 0;
  int   start_cyc = 0;
  int   ack_cyc   = 0;
  int   ack_seen  = 0;
  int   model_lat = 3;
  bit   model_en  = 1'b1;

  logic [3:0]  gnt_prev;
  logic [25:0] cfg_prev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_txn(input int idx, input logic [7:0] din, input logic cpol,
                            input logic cpha, input logic [15:0] dvsr, input logic err);
    txn_t t;
    t.idx  = idx;
    t.din  = din;
    t.cpol = cpol;
    t.cpha = cpha;
    t.dvsr = dvsr;
    t.rx   = err ? 8'hFF : (din ^ 8'h07);
    t.err  = err;
    exp_q.push_back(t);
  endtask

  task automatic drive(input logic [1:0] i, input logic [7:0] d, input logic cp,
                       input logic ch, input logic [15:0] dv);
    bus.req_data[i] = d;
    bus.req_cpol[i] = cp;
    bus.req_cpha[i] = ch;
    bus.req_dvsr[i] = dv;
  endtask

  task automatic wait_ack(output logic [3:0] a, input int budget);
    bit seen = 1'b0;
    a = '0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (bus.ack != 4'b0) begin
        seen = 1'b1;
        a    = bus.ack;
      end
    end
    check("ack_seen", 32'(seen), 1);
  endtask

  task automatic wait_start(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (bus.spi_start) seen = 1'b1;
    end
    check("start_seen", 32'(seen), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'(bus.gnt),       0);
    check({tag, "_ack"},   32'(bus.ack),       0);
    check({tag, "_busy"},  32'(bus.busy),      0);
    check({tag, "_start"}, 32'(bus.spi_start), 0);
    check({tag, "_din"},   32'(bus.spi_din),   0);
    check({tag, "_dvsr"},  32'(bus.spi_dvsr),  0);
    check({tag, "_cpol"},  32'(bus.spi_cpol),  0);
    check({tag, "_cpha"},  32'(bus.spi_cpha),  0);
    check({tag, "_rx"},    32'(bus.rx_data),   0);
  endtask

  // SPI master model.
  initial begin
    logic [7:0] d;
    bus.spi_done = 1'b0;
    bus.spi_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.spi_start && model_en) begin
        d = bus.spi_din;
        repeat (model_lat) @(negedge clk);
        bus.spi_dout = d ^ 8'h07;
        bus.spi_done = 1'b1;
        done_cyc     = cyc;
        @(negedge clk);
        bus.spi_done = 1'b0;
        bus.spi_dout = 8'h5A;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.spi_start) begin
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'(bus.spi_start), 0);
        end else begin
          mon_t = exp_q[0];
          check("start_gnt",  32'(bus.gnt),      32'(1) << mon_t.idx);
          check("start_din",  32'(bus.spi_din),  32'(mon_t.din));
          check("start_cpol", 32'(bus.spi_cpol), 32'(mon_t.cpol));
          check("start_cpha", 32'(bus.spi_cpha), 32'(mon_t.cpha));
          check("start_dvsr", 32'(bus.spi_dvsr), 32'(mon_t.dvsr));
        end
        if (lat_chk) begin
          // The cycle req is first driven counts as cycle 1.
          check("start_latency", 32'(cyc - req_cyc + 1), 3);
          lat_chk = 1'b0;
        end
      end
      if (bus.gnt != 4'b0 && bus.gnt == gnt_prev) begin
        check("cfg_stable", 32'({bus.spi_din, bus.spi_cpol, bus.spi_cpha, bus.spi_dvsr}),
              32'(cfg_prev));
      end
      if (bus.ack != 4'b0) begin
        ack_cyc = cyc;
        ack_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(bus.ack), 0);
        end else begin
          mon_t = exp_q.pop_front();
          check("ack_onehot", 32'(bus.ack),     32'(1) << mon_t.idx);
          check("ack_gnt",    32'(bus.gnt),     32'(1) << mon_t.idx);
          check("ack_rx",     32'(bus.rx_data), 32'(mon_t.rx));
          check("ack_din",    32'(bus.spi_din), 32'(mon_t.din));
`ifdef SPI_TIMEOUT_EN
          check("ack_err",    32'(bus.err),     32'(mon_t.err));
`endif
          if (!mon_t.err) check("done_to_ack", 32'(cyc - done_cyc), 1);
        end
      end
`ifdef SPI_TIMEOUT_EN
      if (bus.err && bus.ack == 4'b0) check("err_without_ack", 32'(bus.err), 0);
`endif
    end
    gnt_prev = bus.gnt;
    cfg_prev = {bus.spi_din, bus.spi_cpol, bus.spi_cpha, bus.spi_dvsr};
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] a;
    int         n0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_cpol = '0;
    bus.req_cpha = '0;
    bus.req_dvsr = '0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single request from requester 0.
    drive(2'd0, 8'hA1, 1'b0, 1'b1, 16'd49);
    expect_txn(0, 8'hA1, 1'b0, 1'b1, 16'd49, 1'b0);
    bus.req = 4'b0001;
    req_cyc = cyc;
    lat_chk = 1'b1;
    wait_ack(a, 40);
    bus.req = 4'b0000;
    check("t1_ack", 32'(a), 32'h1);
    check("t1_rx", 32'(bus.rx_data), 32'hA6);
    @(negedge clk);
    check("t1_busy_drop", 32'(bus.busy), 0);
    repeat (3) @(negedge clk);
    check("t1_rx_hold", 32'(bus.rx_data), 32'hA6);

    // Reset while idle clears rx_data and the pointer.
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("idle_rst");
    @(posedge clk);
    #1 rst = 1'b0;

    // Contention with 1011 held: order 0,1,3,0; dvsr 0 and FFFF pass through.
    drive(2'd0, 8'h11, 1'b1, 1'b0, 16'd7);
    drive(2'd1, 8'h22, 1'b0, 1'b0, 16'd0);
    drive(2'd3, 8'h33, 1'b1, 1'b1, 16'hFFFF);
    expect_txn(0, 8'h11, 1'b1, 1'b0, 16'd7,    1'b0);
    expect_txn(1, 8'h22, 1'b0, 1'b0, 16'd0,    1'b0);
    expect_txn(3, 8'h33, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    expect_txn(0, 8'h11, 1'b1, 1'b0, 16'd7,    1'b0);
    bus.req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_ack(a, 60);
      if (k == 3) begin
        bus.req = 4'b0000;
      end else begin
        @(negedge clk);
        check("gap_busy_low", 32'(bus.busy), 0);
        check("gap_gnt_low",  32'(bus.gnt),  0);
        @(negedge clk);
        check("gap_busy_high", 32'(bus.busy), 1);
      end
    end
    repeat (5) @(negedge clk);

    // Config isolation: pointer is 1, so requester 2 (mode 3) precedes 0 (mode 0).
    drive(2'd0, 8'h3C, 1'b0, 1'b0, 16'd49);
    drive(2'd2, 8'hC3, 1'b1, 1'b1, 16'd4);
    expect_txn(2, 8'hC3, 1'b1, 1'b1, 16'd4,  1'b0);
    expect_txn(0, 8'h3C, 1'b0, 1'b0, 16'd49, 1'b0);
    bus.req = 4'b0101;
    wait_ack(a, 60);
    bus.req[2] = 1'b0;
    wait_ack(a, 60);
    bus.req[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Requester 1 drops req and changes its config while WAIT is in progress.
    model_lat = 6;
    drive(2'd1, 8'h5C, 1'b1, 1'b0, 16'd300);
    expect_txn(1, 8'h5C, 1'b1, 1'b0, 16'd300, 1'b0);
    bus.req = 4'b0010;
    wait_start(60);
    repeat (2) @(negedge clk);
    bus.req[1] = 1'b0;
    drive(2'd1, 8'hFF, 1'b0, 1'b1, 16'h1234);
    wait_ack(a, 60);
    check("drop_ack", 32'(a), 32'h2);
    repeat (3) @(negedge clk);

    // Reset during WAIT; the late spi_done must not produce an ack.
    model_lat = 12;
    drive(2'd2, 8'h99, 1'b0, 1'b1, 16'd10);
    expect_txn(2, 8'h99, 1'b0, 1'b1, 16'd10, 1'b0);
    bus.req = 4'b0100;
    wait_start(60);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    bus.req = 4'b0000;
    #1 check_all_zero("wait_rst");
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    n0 = ack_seen;
    repeat (20) @(negedge clk);
    check("no_ack_after_rst", 32'(ack_seen - n0), 0);

    // After reset requester 0 has priority again.
    model_lat = 3;
    drive(2'd0, 8'h0F, 1'b1, 1'b1, 16'd1);
    drive(2'd2, 8'hF0, 1'b0, 1'b0, 16'd2);
    expect_txn(0, 8'h0F, 1'b1, 1'b1, 16'd1, 1'b0);
    expect_txn(2, 8'hF0, 1'b0, 1'b0, 16'd2, 1'b0);
    bus.req = 4'b0101;
    wait_ack(a, 60);
    check("post_rst_first", 32'(a), 32'h1);
    bus.req[0] = 1'b0;
    wait_ack(a, 60);
    check("post_rst_second", 32'(a), 32'h4);
    bus.req[2] = 1'b0;
    repeat (3) @(negedge clk);

`ifdef SPI_TIMEOUT_EN
    // Silent master: watchdog ends WAIT after TMO cycles with rx 8'hFF and err.
    model_en = 1'b0;
    drive(2'd3, 8'h77, 1'b0, 1'b1, 16'd5);
    expect_txn(3, 8'h77, 1'b0, 1'b1, 16'd5, 1'b1);
    bus.req = 4'b1000;
    wait_ack(a, 80);
    bus.req = 4'b0000;
    check("timeout_latency", 32'(ack_cyc - start_cyc), 32'(TMO + 1));
    check("timeout_rx", 32'(bus.rx_data), 32'hFF);
    @(negedge clk);
    check("timeout_err_clear", 32'(bus.err), 0);
    model_en = 1'b1;
    repeat (3) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
